// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter and sequencer for a shared N-bit bitwise logic unit.
// Accepts one request at a time from two requesters and returns a tagged, registered result.
module alu_share_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [N-1:0] resp_result,
    output logic [1:0]   resp_flags,
    output logic         busy
);
    // Handshakes: a transfer happens on an edge where valid and ready are both high;
    // requesters hold valid/op/operands until ready, the consumer holds resp_ready as it likes.

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state, state_nx;
    logic           last_grant;
    logic           grant;
    logic           accept;
    logic [1:0]     op_q;
    logic [N-1:0]   a_q, b_q;
    logic           id_q;
    logic [N-1:0]   alu_res;

    // Ready is gated by rst so both readies read 0 while reset is held.
    always_comb begin
        grant  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        accept = (state == IDLE) && (req0_valid || req1_valid) && !rst;
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
        end else if (accept) begin
            last_grant <= grant;
            id_q       <= grant;
            op_q       <= grant ? req1_op : req0_op;
            a_q        <= grant ? req1_a  : req0_a;
            b_q        <= grant ? req1_b  : req0_b;
        end
    end

    always_comb begin
        alu_res = '0;
        case (op_q)
            2'b00:   alu_res = ~a_q;
            2'b01:   alu_res = a_q & b_q;
            2'b10:   alu_res = a_q | b_q;
            default: alu_res = a_q ^ b_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_result <= '0;
            resp_flags  <= '0;
            resp_id     <= 1'b0;
        end else if (state == EXEC) begin
            resp_result <= alu_res;
            resp_flags  <= {(alu_res == '0), alu_res[N-1]};
            resp_id     <= id_q;
        end
    end

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: drivers push expected {id, flags, result}
// into a queue, a negedge monitor pops and compares on every response handshake.
module tb_alu_share_arbiter;
    localparam int N = 32;
    localparam int W = 1 + 2 + N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_op = '0, req1_op = '0;
    logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         resp_valid, resp_id, busy;
    logic         resp_ready = 1'b1;
    logic [N-1:0] resp_result;
    logic [1:0]   resp_flags;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_flags(resp_flags), .busy(busy)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got %0h expected none", {resp_id, resp_flags, resp_result});
            end else begin
                chk("resp", {resp_id, resp_flags, resp_result}, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic v, input logic [1:0] op,
                         input logic [N-1:0] a, input logic [N-1:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic do_req(input logic id, input logic [1:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [W-1:0] exp, input string name);
        logic ok;
        drive(id, 1'b1, op, a, b);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = id ? req1_ready : req0_ready;
        end
        chk({name, "_accept"}, ok, 1);
        if (ok) exp_q.push_back(exp);
        step();
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 30 && !idle; i++) begin
            @(negedge clk);
            idle = !busy && !resp_valid;
        end
        chk({name, "_idle"}, idle, 1);
        step();
    endtask

    task automatic wait_resp(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = resp_valid;
        end
        chk({name, "_resp_valid"}, seen, 1);
    endtask

    // after a reset, both requesting: requester 0 must win first
    task automatic rr_after_reset(input string name);
        drive(1'b0, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'h8000_0000);
        drive(1'b1, 1'b1, 2'b10, 32'h0000_0001, 32'h0000_0002);
        @(negedge clk);
        chk({name, "_req0_first"}, {req0_ready, req1_ready}, 2'b10);
        if (req0_ready) exp_q.push_back({1'b0, 2'b01, 32'h8000_0000});
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle(name);
    endtask

    initial begin
        logic [W-1:0] rr_exp [3];
        logic [1:0]   rr_gnt [3];
        logic         got;

        // reset values
        #2;
        chk("reset_outputs", {req0_ready, req1_ready, resp_valid, resp_id, resp_result, resp_flags, busy}, '0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // NOT path, requester 0
        do_req(1'b0, 2'b00, 32'h0000_00FF, 32'h0, {1'b0, 2'b01, 32'hFFFF_FF00}, "not0");
        @(negedge clk);
        chk("not0_ready_one_cycle", req0_ready, 0);
        chk("not0_exec_busy", {busy, resp_valid}, 2'b10);
        step();
        @(negedge clk);
        chk("not0_resp_valid", resp_valid, 1);
        wait_idle("not0");

        // simultaneous requests, round-robin from reset
        #2 rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        step();
        rr_gnt = '{2'd0, 2'd1, 2'd0};
        rr_exp = '{{1'b0, 2'b10, 32'h0}, {1'b1, 2'b10, 32'h0}, {1'b0, 2'b10, 32'h0}};
        drive(1'b0, 1'b1, 2'b01, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        drive(1'b1, 1'b1, 2'b11, 32'h1234_5678, 32'h1234_5678);
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = req0_ready || req1_ready;
            end
            chk("rr_grant_seen", got, 1);
            chk("rr_grant_id", {req1_ready, req0_ready}, (rr_gnt[k] == 2'd1) ? 2'b10 : 2'b01);
            exp_q.push_back(rr_exp[k]);
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle("rr");

        // backpressure with requester 1 waiting
        resp_ready = 1'b0;
        do_req(1'b0, 2'b01, 32'hFFFF_0000, 32'hFF00_FF00, {1'b0, 2'b01, 32'hFF00_0000}, "bp0");
        drive(1'b1, 1'b1, 2'b11, 32'hAAAA_5555, 32'hFFFF_FFFF);
        wait_resp("bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_resp", {resp_valid, resp_id, resp_flags, resp_result}, {1'b1, 1'b0, 2'b01, 32'hFF00_0000});
            chk("bp_no_req1_ready", {req1_ready, busy}, 2'b01);
            @(negedge clk);
        end
        step();
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_req1_after_handshake", req1_ready, 1);
        if (req1_ready) exp_q.push_back({1'b1, 2'b00, 32'h5555_AAAA});
        step();
        req1_valid = 1'b0;
        wait_idle("bp1");

        // operand isolation
        do_req(1'b0, 2'b10, 32'h8000_0000, 32'h0000_0001, {1'b0, 2'b01, 32'h8000_0001}, "iso");
        req0_a = 32'h0000_0000;
        req0_b = 32'hFFFF_FFFE;
        wait_idle("iso");

        // reset mid-EXEC
        do_req(1'b1, 2'b10, 32'h0000_000F, 32'h0000_00F0, {1'b1, 2'b00, 32'h0000_00FF}, "rexec");
        #2 rst = 1'b1;
        #1;
        chk("rexec_outputs", {busy, resp_valid}, 2'b00);
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rexec_no_resp", {resp_valid, busy}, 2'b00);
        end
        step();
        rr_after_reset("rexec");

        // reset mid-RESP, requester 1 holding valid through the reset
        resp_ready = 1'b0;
        do_req(1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0, {1'b1, 2'b10, 32'h0}, "rresp");
        wait_resp("rresp");
        req1_valid = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rresp_outputs", {req0_ready, req1_ready, resp_valid, resp_id, resp_result, resp_flags, busy}, '0);
        exp_q.delete();
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("rresp_after_release", {resp_valid, busy}, 2'b00);
        step();
        rr_after_reset("rresp");

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter and sequencer for a shared N-bit bitwise logic unit (NOT, AND, OR, XOR). It sits between the execute stage and a secondary requester, such as a vector or test port, that both need logic operations. It grants one request at a time with round-robin priority, latches the operands, computes the result with zero/negative flags into a register, and returns it over a valid/ready response channel tagged with the requester id.

## Interface
- N, default 32: operand and result width (N ≥ 2).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_op  in  2  opcode: 00 NOT (~a, b ignored), 01 AND, 10 OR, 11 XOR.
- req0_a, req0_b  in  N  requester 0 operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_id  out  1  requester that issued the result.
- resp_result  out  N  registered result.
- resp_flags  out  2  [1] Z (result == 0), [0] NEG (result[N-1]).
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE.**
  - If any reqX_valid is high, grant one requester. req<g>_ready is high combinationally in this cycle.
  - On the clock edge, latch op, a, b and id = g, then go to EXEC.
  - If no valid is high, stay in IDLE. All ready signals are low.
- **Arbitration (round-robin).**
  - Register last_grant resets to 1, so requester 0 has priority first.
  - With both valids high, grant the requester that is not last_grant.
  - With one valid high, grant that requester regardless of last_grant.
  - Update last_grant to g on every accept.
- **EXEC.**
  - Compute from the latched operands: NOT = ~a; AND = a & b; OR = a | b; XOR = a ^ b. All are N bits wide, with no shifting or truncation.
  - On the edge, register the result and flags, and set resp_id from the latched id. Go to RESP.
- **RESP.**
  - resp_valid is high. resp_result, resp_flags and resp_id are held stable until resp_ready.
  - When resp_valid and resp_ready are both high at an edge, go to IDLE.
  - No new request is accepted while in EXEC or RESP. Both ready signals are low in those states.
- **Requester rules.**
  - A requester keeps valid, op and operands stable until it sees ready.
  - Valid may drop without a handshake. No accept happens, and the block keeps no state about that request.
  - Operand changes after acceptance do not affect the result in flight.
- **Reset, including mid-operation.**
  - State goes to IDLE and last_grant to 1.
  - resp_valid, resp_id, resp_result, resp_flags, busy and both ready signals go to 0.
  - Any in-flight request is discarded without a response.

## Timing
- Accept edge T (readyX high in the cycle before T).
- T+1: result registered, resp_valid high.
- Earliest resp_valid is 1 cycle after accept. The earliest next accept is in the cycle after the resp handshake edge, giving at most one operation per 3 cycles.
- busy is high from T through the resp handshake edge.
- Ready signals are combinational from the valid inputs, state and last_grant. All other outputs are registered.

## Test plan
- **Reset values.** Assert rst asynchronously mid-cycle. Required: all outputs 0 immediately, and state IDLE after release.
- **NOT path, requester 0.** req0 NOT with a=0x0000_00FF, N=32. Required: req0_ready for 1 cycle; resp_valid 1 cycle later with result=0xFFFF_FF00, flags=01, id=0.
- **Simultaneous requests, round-robin.**
  - Stimulus: from reset, req0 and req1 both valid, continuously. req0 is AND with a=0xF0F0_F0F0, b=0x0F0F_0F0F; req1 is XOR with a=b=0x1234_5678.
  - Required: grants alternate 0, 1, 0. The AND result is 0 with flags=10; the XOR result is 0 with flags=10 and id=1.
- **Backpressure.** Hold resp_ready=0 for 5 cycles with req1 valid. Required: resp outputs stable, no req1_ready, busy=1; req1 is accepted in the cycle after the handshake.
- **Operand isolation.** Change req0_a after acceptance (OR with a=0x8000_0000, b=0x1). Required: result=0x8000_0001, flags=01.
- **Reset mid-EXEC and mid-RESP.** Assert rst in each state. Required: no resp_valid and busy=0; the next request goes to requester 0 first.
